virtual_ds2431_rom_read_rom: RTL

// - Read ROM (0x33) responder for the virtual DS2431 1-Wire slave: transmits the 64-bit romID to the master, LSB byte first, one byte per handshake with the byte transceiver.
// - Transmit-side counterpart of the Match ROM command handler. Sits on the same ROM-command dispatch bus (cmdRunTrig / transTrig / ByteTransDone / cmdDone / cmdFailed).

---
 rtl/virtual_ds2431_pkg.sv | 33 +++
 rtl/virtual_ds2431_rom_read_rom_if.sv | 23 ++
 rtl/ds_crc8_acc.sv | 22 ++
 rtl/posPulse.sv | 19 +
 rtl/virtual_ds2431_rom_read_rom.sv | 119 +++++++++++
 5 files changed

// File: rtl/virtual_ds2431_pkg.sv
// Shared definitions for the virtual DS2431 1-Wire slave: ROM command codes,
// ROM size, ROM-command FSM states and the Dallas CRC8 byte step.
package virtual_ds2431_pkg;

  localparam logic [7:0] READ_ROM     = 8'h33;
  localparam logic [7:0] MATCH_ROM    = 8'h55;
  localparam logic [7:0] SEARCH_ROM   = 8'hF0;
  localparam logic [7:0] SKIP_ROM     = 8'hCC;
  localparam logic [7:0] RESUME       = 8'hA5;
  localparam logic [7:0] OD_SKIP_ROM  = 8'h3C;
  localparam logic [7:0] OD_MATCH_ROM = 8'h69;

  localparam int ROM_BYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT,
    ST_DONE
  } rom_cmd_state_t;

  // x^8+x^5+x^4+1 in reflected form, bits consumed LSB first
  function automatic logic [7:0] crc8_dallas_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/virtual_ds2431_rom_read_rom_if.sv
// ROM-command dispatch bus plus byte-transceiver handshake for the Read ROM
// responder; master = dispatcher/transceiver side, slave = responder.
interface virtual_ds2431_rom_read_rom_if;
  logic [63:0] romID;
  logic        cmdRunTrig;
  logic        busReset;
  logic [7:0]  transmitDat;
  logic        nRxTx;
  logic        transTrig;
  logic        ByteTransDone;
  logic        cmdDone;
  logic        cmdFailed;

  modport master (
    output romID, cmdRunTrig, busReset, ByteTransDone,
    input  transmitDat, nRxTx, transTrig, cmdDone, cmdFailed
  );

  modport slave (
    input  romID, cmdRunTrig, busReset, ByteTransDone,
    output transmitDat, nRxTx, transTrig, cmdDone, cmdFailed
  );
endinterface

// File: rtl/ds_crc8_acc.sv
// Dallas CRC8 accumulator; only compiled when READ_ROM_CRC_GEN_EN is defined.
// clr restarts from 0x00; clr together with load folds data into a fresh CRC.
`ifdef READ_ROM_CRC_GEN_EN
module ds_crc8_acc
  import virtual_ds2431_pkg::*;
(
  input  logic       clk,
  input  logic       nRst,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)     crc <= 8'h00;
    else if (load) crc <= crc8_dallas_byte(clr ? 8'h00 : crc, data);
    else if (clr)  crc <= 8'h00;
  end

endmodule
`endif

// File: rtl/posPulse.sv
// Rising-edge detector: one-clk pulse when sig goes 0->1, based on a
// single registered history bit.
module posPulse (
  input  logic clk,
  input  logic nRst,
  input  logic sig,
  output logic pulse
);

  logic sig_d;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) sig_d <= 1'b0;
    else       sig_d <= sig;
  end

  assign pulse = sig & ~sig_d;

endmodule

// File: rtl/virtual_ds2431_rom_read_rom.sv
// Read ROM (0x33) responder: streams romID LSB byte first, one byte per
// transceiver handshake. READ_ROM_CRC_GEN_EN replaces the last byte by a generated CRC8.
module virtual_ds2431_rom_read_rom
  import virtual_ds2431_pkg::*;
#(
  parameter int BYTE_COUNT     = ROM_BYTES,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic                          clk,
  input logic                          nRst,
  virtual_ds2431_rom_read_rom_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  rom_cmd_state_t state;
  logic [2:0]     byte_idx;
  logic [TW-1:0]  timer;
  logic           run_pos, done_pos;
  logic [2:0]     next_idx;
  logic           last_byte, timeout_hit;
  logic [7:0]     raw_byte, next_byte;

  posPulse u_run_edge  (.clk(clk), .nRst(nRst), .sig(bus.cmdRunTrig),    .pulse(run_pos));
  posPulse u_done_edge (.clk(clk), .nRst(nRst), .sig(bus.ByteTransDone), .pulse(done_pos));

  assign next_idx    = byte_idx + 3'd1;
  assign last_byte   = (byte_idx == 3'(BYTE_COUNT - 1));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TMAX);
  assign raw_byte    = bus.romID[{next_idx, 3'b000} +: 8];

`ifdef READ_ROM_CRC_GEN_EN
  // CRC folds in every byte as it is loaded, so it is complete before the final byte loads
  logic [7:0] crc;
  logic       load_first, load_next;

  assign load_first = !bus.busReset && run_pos;
  assign load_next  = !bus.busReset && !run_pos && (state == ST_WAIT) && done_pos &&
                      !last_byte && (next_idx != 3'(ROM_BYTES - 1));

  ds_crc8_acc u_crc (
    .clk  (clk),
    .nRst (nRst),
    .clr  (load_first),
    .load (load_first || load_next),
    .data (load_first ? bus.romID[7:0] : raw_byte),
    .crc  (crc)
  );

  assign next_byte = (next_idx == 3'(ROM_BYTES - 1)) ? crc : raw_byte;
`else
  assign next_byte = raw_byte;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state           <= ST_IDLE;
      byte_idx        <= 3'd0;
      timer           <= '0;
      bus.transmitDat <= 8'h00;
      bus.nRxTx       <= 1'b0;
      bus.transTrig   <= 1'b0;
      bus.cmdDone     <= 1'b0;
      bus.cmdFailed   <= 1'b0;
    end else begin
      bus.transTrig <= 1'b0;
      if (bus.busReset) begin
        if (state != ST_IDLE) begin
          state         <= ST_IDLE;
          bus.cmdFailed <= 1'b1;
          bus.cmdDone   <= 1'b0;
          bus.nRxTx     <= 1'b0;
        end
      end else if (run_pos) begin
        // restart is legal from any state
        state           <= ST_TRIG;
        byte_idx        <= 3'd0;
        bus.transmitDat <= bus.romID[7:0];
        bus.cmdDone     <= 1'b0;
        bus.cmdFailed   <= 1'b0;
        bus.nRxTx       <= 1'b1;
        bus.transTrig   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_TRIG: begin
            timer <= '0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (done_pos) begin
              if (last_byte) begin
                state       <= ST_DONE;
                bus.cmdDone <= 1'b1;
                bus.nRxTx   <= 1'b0;
              end else begin
                byte_idx        <= next_idx;
                bus.transmitDat <= next_byte;
                bus.transTrig   <= 1'b1;
                state           <= ST_TRIG;
              end
            end else begin
              if (timer != '1) timer <= timer + 1'b1;
              if (timeout_hit) begin
                state         <= ST_IDLE;
                bus.cmdFailed <= 1'b1;
                bus.nRxTx     <= 1'b0;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
